intersection_phase_arbiter: RTL and testbench

- Sequences the single intersection resource (main road, side road, pedestrian crossing) by granting exclusive phases to three requesters: main traffic (default owner), side-road sensor, walk button.
- Drives light codes that feed the existing 7-segment display mux, plus a countdown for display.
- Advances only on a 1-tick-per-second enable from the existing clock divider.
- Inserts yellow and all-red clearance between conflicting grants.

---
 rtl/intersection_phase_arbiter.sv | 135 +++++++++++++
 tb/tb_intersection_phase_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/intersection_phase_arbiter.sv
// Grants the shared intersection to main road, side road or pedestrians in
// exclusive phases, with yellow and all-red clearance between conflicting grants.
module intersection_phase_arbiter #(
  parameter int T_MIN_GREEN = 8,
  parameter int T_SIDE      = 6,
  parameter int T_EXT       = 3,
  parameter int T_YEL       = 2,
  parameter int T_CLR       = 1,
  parameter int T_WALK      = 5,
  parameter int CW          = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          side_req,
  input  logic          walk_btn,
  output logic [1:0]    main_light,
  output logic [1:0]    side_light,
  output logic          walk_light,
  output logic [2:0]    phase,
  output logic [CW-1:0] countdown,
  output logic          side_pending,
  output logic          walk_pending
);

  typedef enum logic [2:0] {
    INIT_RED = 3'd0,
    MAIN_G   = 3'd1,
    MAIN_Y   = 3'd2,
    CLR      = 3'd3,
    SIDE_G   = 3'd4,
    SIDE_Y   = 3'd5,
    WALK     = 3'd6
  } state_t;

  localparam logic [CW-1:0] L_MIN  = CW'(T_MIN_GREEN - 1);
  localparam logic [CW-1:0] L_SIDE = CW'(T_SIDE - 1);
  localparam logic [CW-1:0] L_EXT  = CW'(T_EXT - 1);
  localparam logic [CW-1:0] L_YEL  = CW'(T_YEL - 1);
  localparam logic [CW-1:0] L_CLR  = CW'(T_CLR - 1);
  localparam logic [CW-1:0] L_WALK = CW'(T_WALK - 1);

  state_t          state, nxt, dest, nxt_dest;
  logic [CW-1:0]   nxt_cd;
  logic            ext_used, nxt_ext;
  logic            last_walk;
  logic            enter_side, enter_walk;

  // {main_light, side_light, walk_light} shown while in a given state
  function automatic logic [4:0] lights_of(input state_t s);
    case (s)
      MAIN_G:  lights_of = {2'd1, 2'd3, 1'b0};
      MAIN_Y:  lights_of = {2'd2, 2'd3, 1'b0};
      SIDE_G:  lights_of = {2'd3, 2'd1, 1'b0};
      SIDE_Y:  lights_of = {2'd3, 2'd2, 1'b0};
      WALK:    lights_of = {2'd3, 2'd3, 1'b1};
      default: lights_of = {2'd3, 2'd3, 1'b0};
    endcase
  endfunction

  always_comb begin
    nxt      = state;
    nxt_cd   = countdown;
    nxt_dest = dest;
    nxt_ext  = ext_used;
    if (tick) begin
      if (countdown != '0) begin
        nxt_cd = countdown - CW'(1);
      end else begin
        case (state)
          INIT_RED: begin nxt = MAIN_G; nxt_cd = L_MIN; end
          MAIN_G: begin
            // Rest in main with countdown parked at 0 until someone asks.
            if (side_pending || walk_pending) begin
              nxt = MAIN_Y; nxt_cd = L_YEL;
            end
          end
          MAIN_Y: begin
            nxt = CLR; nxt_cd = L_CLR;
            if (side_pending && walk_pending) nxt_dest = last_walk ? SIDE_G : WALK;
            else if (walk_pending)            nxt_dest = WALK;
            else                              nxt_dest = SIDE_G;
          end
          CLR: begin
            nxt = dest;
            case (dest)
              SIDE_G:  begin nxt_cd = L_SIDE; nxt_ext = 1'b0; end
              WALK:    nxt_cd = L_WALK;
              default: nxt_cd = L_MIN;
            endcase
          end
          SIDE_G: begin
            if (side_req && !ext_used) begin
              nxt_cd = L_EXT; nxt_ext = 1'b1;
            end else begin
              nxt = SIDE_Y; nxt_cd = L_YEL;
            end
          end
          SIDE_Y: begin nxt = CLR; nxt_cd = L_CLR; nxt_dest = MAIN_G; end
          WALK:   begin nxt = MAIN_G; nxt_cd = L_MIN; end
          default: begin nxt = INIT_RED; nxt_cd = L_CLR; end
        endcase
      end
    end
  end

  assign enter_side = (nxt == SIDE_G) && (state != SIDE_G);
  assign enter_walk = (nxt == WALK) && (state != WALK);
  assign phase      = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= INIT_RED;
      dest         <= MAIN_G;
      countdown    <= L_CLR;
      ext_used     <= 1'b0;
      last_walk    <= 1'b1;
      side_pending <= 1'b0;
      walk_pending <= 1'b0;
      {main_light, side_light, walk_light} <= {2'd3, 2'd3, 1'b0};
    end else begin
      state     <= nxt;
      dest      <= nxt_dest;
      countdown <= nxt_cd;
      ext_used  <= nxt_ext;
      if (enter_side) last_walk <= 1'b0;
      if (enter_walk) last_walk <= 1'b1;
      // A request coinciding with its own grant is considered served.
      side_pending <= enter_side ? 1'b0 : (side_pending | side_req);
      walk_pending <= enter_walk ? 1'b0 : (walk_pending | walk_btn);
      {main_light, side_light, walk_light} <= lights_of(nxt);
    end
  end

endmodule

// File: tb/tb_intersection_phase_arbiter.sv
// Directed bench: drivers push expected post-tick outputs into a queue, a
// monitor pops and compares after every tick or reset edge.
module tb_intersection_phase_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       side_req = 1'b0;
  logic       walk_btn = 1'b0;
  logic [1:0] main_light, side_light;
  logic       walk_light;
  logic [2:0] phase;
  logic [3:0] countdown;
  logic       side_pending, walk_pending;

  logic [13:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  logic side_hold = 1'b0;
  logic s_pulse = 1'b0;
  logic w_pulse = 1'b0;
  logic sample = 1'b0;

  intersection_phase_arbiter dut (
    .clk(clk), .reset(reset), .tick(tick), .side_req(side_req), .walk_btn(walk_btn),
    .main_light(main_light), .side_light(side_light), .walk_light(walk_light),
    .phase(phase), .countdown(countdown),
    .side_pending(side_pending), .walk_pending(walk_pending)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] light_table(input logic [2:0] ph);
    case (ph)
      3'd1:    light_table = {2'd1, 2'd3, 1'b0};
      3'd2:    light_table = {2'd2, 2'd3, 1'b0};
      3'd4:    light_table = {2'd3, 2'd1, 1'b0};
      3'd5:    light_table = {2'd3, 2'd2, 1'b0};
      3'd6:    light_table = {2'd3, 2'd3, 1'b1};
      default: light_table = {2'd3, 2'd3, 1'b0};
    endcase
  endfunction

  function automatic logic [13:0] pack(input logic [2:0] ph, input logic [3:0] cd,
                                       input logic sp, input logic wp);
    pack = {ph, light_table(ph), cd, sp, wp};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    tick  = 1'b1;
    exp_q.push_back(pack(3'd0, 4'd0, 1'b0, 1'b0));
    @(posedge clk); #1;
    reset = 1'b0;
    tick  = 1'b0;
    @(posedge clk); #1;
  endtask

  // n ticks in phase ph, countdown starting at first_cd and parking at 0.
  task automatic seq(input logic [2:0] ph, input int first_cd, input int n,
                     input logic sp, input logic wp);
    for (int i = 0; i < n; i++) begin
      tick     = 1'b1;
      side_req = side_hold | s_pulse;
      walk_btn = w_pulse;
      exp_q.push_back(pack(ph, 4'((first_cd > i) ? first_cd - i : 0), sp, wp));
      @(posedge clk); #1;
      tick     = 1'b0;
      walk_btn = 1'b0;
      s_pulse  = 1'b0;
      w_pulse  = 1'b0;
      side_req = side_hold;
      @(posedge clk); #1;
    end
  endtask

  always @(posedge clk) sample <= tick | reset;

  always @(negedge clk) begin
    if (sample) begin
      logic [13:0] act, exp_v;
      act = {phase, main_light, side_light, walk_light, countdown, side_pending, walk_pending};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_sample: got %h, queue empty", act);
      end else begin
        exp_v = exp_q.pop_front();
        if (act !== exp_v) begin
          errors++;
          $display("FAIL outputs @%0t: got ph=%0d m=%0d s=%0d w=%0d cd=%0d sp=%0d wp=%0d want ph=%0d m=%0d s=%0d w=%0d cd=%0d sp=%0d wp=%0d",
                   $time, act[13:11], act[10:9], act[8:7], act[6], act[5:2], act[1], act[0],
                   exp_v[13:11], exp_v[10:9], exp_v[8:7], exp_v[6], exp_v[5:2], exp_v[1], exp_v[0]);
        end
      end
    end
  end

  initial begin
    @(posedge clk); #1;

    // idle: INIT_RED for one tick, then rest in MAIN_G
    do_reset();
    seq(3'd1, 7, 20, 1'b0, 1'b0);

    // single side pulse, no extension
    do_reset();
    seq(3'd1, 7, 1, 1'b0, 1'b0);
    seq(3'd1, 6, 1, 1'b0, 1'b0);
    s_pulse = 1'b1;
    seq(3'd1, 5, 6, 1'b1, 1'b0);
    seq(3'd2, 1, 2, 1'b1, 1'b0);
    seq(3'd3, 0, 1, 1'b1, 1'b0);
    seq(3'd4, 5, 6, 1'b0, 1'b0);
    seq(3'd5, 1, 2, 1'b0, 1'b0);
    seq(3'd3, 0, 1, 1'b0, 1'b0);
    seq(3'd1, 7, 1, 1'b0, 1'b0);

    // side held: one extension only
    do_reset();
    side_hold = 1'b1;
    seq(3'd1, 7, 8, 1'b1, 1'b0);
    seq(3'd2, 1, 2, 1'b1, 1'b0);
    seq(3'd3, 0, 1, 1'b1, 1'b0);
    seq(3'd4, 5, 1, 1'b0, 1'b0);
    seq(3'd4, 4, 5, 1'b1, 1'b0);
    seq(3'd4, 2, 3, 1'b1, 1'b0);
    side_hold = 1'b0;
    seq(3'd5, 1, 2, 1'b1, 1'b0);
    seq(3'd3, 0, 1, 1'b1, 1'b0);
    seq(3'd1, 7, 1, 1'b1, 1'b0);

    // walk request
    do_reset();
    seq(3'd1, 7, 1, 1'b0, 1'b0);
    w_pulse = 1'b1;
    seq(3'd1, 6, 7, 1'b0, 1'b1);
    seq(3'd2, 1, 2, 1'b0, 1'b1);
    seq(3'd3, 0, 1, 1'b0, 1'b1);
    seq(3'd6, 4, 5, 1'b0, 1'b0);
    seq(3'd1, 7, 1, 1'b0, 1'b0);

    // both pending: SIDE, WALK, SIDE
    do_reset();
    side_hold = 1'b1;
    seq(3'd1, 7, 1, 1'b1, 1'b0);
    w_pulse = 1'b1;
    seq(3'd1, 6, 7, 1'b1, 1'b1);
    seq(3'd2, 1, 2, 1'b1, 1'b1);
    seq(3'd3, 0, 1, 1'b1, 1'b1);
    seq(3'd4, 5, 1, 1'b0, 1'b1);
    seq(3'd4, 4, 5, 1'b1, 1'b1);
    seq(3'd4, 2, 3, 1'b1, 1'b1);
    seq(3'd5, 1, 2, 1'b1, 1'b1);
    seq(3'd3, 0, 1, 1'b1, 1'b1);
    w_pulse = 1'b1;
    seq(3'd1, 7, 8, 1'b1, 1'b1);
    seq(3'd2, 1, 2, 1'b1, 1'b1);
    seq(3'd3, 0, 1, 1'b1, 1'b1);
    seq(3'd6, 4, 5, 1'b1, 1'b0);
    seq(3'd1, 7, 8, 1'b1, 1'b0);
    seq(3'd2, 1, 2, 1'b1, 1'b0);
    seq(3'd3, 0, 1, 1'b1, 1'b0);
    side_hold = 1'b0;
    seq(3'd4, 5, 1, 1'b0, 1'b0);

    // reset mid SIDE_G (countdown 3), then walk press coinciding with WALK entry
    do_reset();
    seq(3'd1, 7, 1, 1'b0, 1'b0);
    s_pulse = 1'b1;
    seq(3'd1, 6, 7, 1'b1, 1'b0);
    seq(3'd2, 1, 2, 1'b1, 1'b0);
    seq(3'd3, 0, 1, 1'b1, 1'b0);
    seq(3'd4, 5, 3, 1'b0, 1'b0);
    do_reset();
    seq(3'd1, 7, 1, 1'b0, 1'b0);
    w_pulse = 1'b1;
    seq(3'd1, 6, 7, 1'b0, 1'b1);
    seq(3'd2, 1, 2, 1'b0, 1'b1);
    seq(3'd3, 0, 1, 1'b0, 1'b1);
    w_pulse = 1'b1;
    seq(3'd6, 4, 1, 1'b0, 1'b0);
    seq(3'd6, 3, 1, 1'b0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expected results left, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
